// File: rtl/sbqm_param.sv
// Parametrised bank queue manager: counts arrivals/departures and estimates wait time.
// Optional sensor debouncing is enabled by defining SBQM_DEBOUNCE_EN.
module sbqm_param #(
    parameter int DEPTH           = 7,
    parameter int TELLER_W        = 2,
    parameter int SERVICE_TIME    = 3,
    parameter int WT_W            = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a,
    input  logic                b,
    input  logic [TELLER_W-1:0] tCount,
    input  logic                clrErr,
    output logic [CNT_W-1:0]    pCount,
    output logic [WT_W-1:0]     wTime,
    output logic                wValid,
    output logic                emptyFlag,
    output logic                fullFlag,
    output logic                ovfFlag,
    output logic                udfFlag
);

    localparam int NUM_W = CNT_W + 1;
    localparam int REM_W = NUM_W + 1;
    localparam int BIT_W = $clog2(NUM_W);
    localparam int PW    = NUM_W + 32;
    localparam logic [PW-1:0] WT_MAX = (PW'(1) << WT_W) - PW'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;

    function automatic logic [WT_W-1:0] sat_mul(input logic [NUM_W-1:0] q);
        logic [PW-1:0] prod;
        prod = {32'd0, q} * PW'(SERVICE_TIME);
        if (prod > WT_MAX) return '1;
        return prod[WT_W-1:0];
    endfunction

    // Sensor path; index 0 is the back sensor (a), index 1 the front sensor (b).
    // History resets high so a sensor already high at reset release is not an edge.
    logic [1:0] sens, s1_q, s2_q, lvl, prev_q, evt;
    assign sens = {b, a};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= 2'b11;
            s2_q   <= 2'b11;
            prev_q <= 2'b11;
        end else begin
            s1_q   <= sens;
            s2_q   <= s1_q;
            prev_q <= lvl;
        end
    end

`ifdef SBQM_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]      db_q;
    logic [DB_W-1:0] dbc_q [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q <= 2'b11;
            for (int i = 0; i < 2; i++) dbc_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == db_q[i]) begin
                    dbc_q[i] <= '0;
                end else if (dbc_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_q[i]  <= s2_q[i];
                    dbc_q[i] <= '0;
                end else begin
                    dbc_q[i] <= dbc_q[i] + DB_W'(1);
                end
            end
        end
    end
    assign lvl = db_q;
`else
    assign lvl = s2_q;
`endif

    assign evt = lvl & ~prev_q;

    // Occupancy counter and status flags
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, full_q, ovf_q, udf_q;
    logic             ovf_set, udf_set;
    logic             is_empty, is_full;

    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CNT_W'(DEPTH));

    always_comb begin
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        unique case (evt)
            2'b01: if (is_full) ovf_set = 1'b1; else cnt_d = cnt_q + CNT_W'(1);
            2'b10: if (is_empty) udf_set = 1'b1; else cnt_d = cnt_q - CNT_W'(1);
            2'b11: if (is_empty) cnt_d = CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CNT_W'(DEPTH));
            ovf_q   <= ovf_set | (ovf_q & ~clrErr);
            udf_q   <= udf_set | (udf_q & ~clrErr);
        end
    end

    // Wait-time divider
    state_t              state_q, state_d;
    logic [TELLER_W-1:0] tc_q;
    logic [WT_W-1:0]     wtime_q, wtime_d;
    logic                wvalid_q, wvalid_d;
    logic                sat_q, sat_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [REM_W-1:0]    rem_q, rem_d, rem_sh, div_ext;
    logic [NUM_W-1:0]    quo_q, quo_d, num;
    logic [TELLER_W-1:0] div_q, div_d;
    logic                chg;

    assign chg     = (cnt_d != cnt_q) || (tCount != tc_q);
    assign num     = {1'b0, cnt_q} + NUM_W'(tc_q) - NUM_W'(1);
    assign rem_sh  = {rem_q[REM_W-2:0], quo_q[NUM_W-1]};
    assign div_ext = {{(REM_W - TELLER_W){1'b0}}, div_q};

    always_comb begin
        state_d  = state_q;
        wtime_d  = wtime_q;
        wvalid_d = wvalid_q;
        sat_d    = sat_q;
        bit_d    = bit_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        if (chg) begin
            // Any input change (re)starts from LOAD, including mid-computation.
            state_d  = S_LOAD;
            wvalid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    div_d = tc_q;
                    rem_d = '0;
                    quo_d = num;
                    bit_d = '0;
                    sat_d = 1'b0;
                    if (cnt_q == '0) begin
                        quo_d   = '0;
                        state_d = S_DONE;
                    end else if (tc_q == '0) begin
                        sat_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
                S_DIV: begin
                    if (rem_sh >= div_ext) begin
                        rem_d = rem_sh - div_ext;
                        quo_d = {quo_q[NUM_W-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh;
                        quo_d = {quo_q[NUM_W-2:0], 1'b0};
                    end
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == BIT_W'(NUM_W - 1)) state_d = S_DONE;
                end
                S_DONE: begin
                    wtime_d  = sat_q ? '1 : sat_mul(quo_q);
                    wvalid_d = 1'b1;
                    state_d  = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            tc_q     <= '0;
            wtime_q  <= '0;
            wvalid_q <= 1'b1;
            sat_q    <= 1'b0;
            bit_q    <= '0;
        end else begin
            state_q  <= state_d;
            tc_q     <= tCount;
            wtime_q  <= wtime_d;
            wvalid_q <= wvalid_d;
            sat_q    <= sat_d;
            bit_q    <= bit_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        div_q <= div_d;
    end

    assign pCount    = cnt_q;
    assign wTime     = wtime_q;
    assign wValid    = wvalid_q;
    assign emptyFlag = empty_q;
    assign fullFlag  = full_q;
    assign ovfFlag   = ovf_q;
    assign udfFlag   = udf_q;

endmodule

// File: tb/tb_sbqm_param.sv
// Directed self-checking bench for sbqm_param (default parameters).
module tb_sbqm_param;

    localparam int DBC = 4;
`ifdef SBQM_DEBOUNCE_EN
    localparam int EXTRA = DBC;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       a = 1'b0, b = 1'b0, clrErr = 1'b0;
    logic [1:0] tCount = 2'd0;
    logic [2:0] pCount;
    logic [7:0] wTime;
    logic       wValid, emptyFlag, fullFlag, ovfFlag, udfFlag;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sbqm_param #(
        .DEPTH(7), .TELLER_W(2), .SERVICE_TIME(3), .WT_W(8), .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .tCount(tCount), .clrErr(clrErr),
        .pCount(pCount), .wTime(wTime), .wValid(wValid), .emptyFlag(emptyFlag),
        .fullFlag(fullFlag), .ovfFlag(ovfFlag), .udfFlag(udfFlag)
    );

    task automatic pulse_a(input int n);
        @(posedge clk); #1 a = 1'b1;
        repeat (n) @(posedge clk);
        #1 a = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic pulse_b(input int n);
        @(posedge clk); #1 b = 1'b1;
        repeat (n) @(posedge clk);
        #1 b = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic test_reset;
        a = 1'b1; b = 1'b1; tCount = 2'd3; reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({pCount, wValid, emptyFlag} !== {3'd0, 1'b1, 1'b1})
            $display("FAIL reset_held: pCount/wValid/empty=%0d/%b/%b expected 0/1/1", pCount, wValid, emptyFlag);
        else n_pass++;
        @(posedge clk); #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (pCount !== 3'd0) $display("FAIL reset_pcount: got %0d expected 0", pCount);
        else n_pass++;
        n_total++;
        if ({emptyFlag, wValid, wTime} !== {1'b1, 1'b1, 8'd0})
            $display("FAIL reset_outputs: empty/wValid/wTime=%b/%b/%0d expected 1/1/0", emptyFlag, wValid, wTime);
        else n_pass++;
        n_total++;
        if ({fullFlag, ovfFlag, udfFlag} !== 3'b000)
            $display("FAIL reset_flags: full/ovf/udf=%b/%b/%b expected 0/0/0", fullFlag, ovfFlag, udfFlag);
        else n_pass++;
        a = 1'b0; b = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (pCount !== 3'd0) $display("FAIL reset_release_event: pCount=%0d expected 0", pCount);
        else n_pass++;
    endtask

    task automatic test_fill;
        int hi_at;
        logic held_ok;
        repeat (6) pulse_a(8);
        @(negedge clk);
        n_total++;
        if ({pCount, wValid, wTime} !== {3'd6, 1'b1, 8'd6})
            $display("FAIL fill_six: pCount/wValid/wTime=%0d/%b/%0d expected 6/1/6", pCount, wValid, wTime);
        else n_pass++;
        @(posedge clk); #1 a = 1'b1;
        repeat (2 + EXTRA) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (pCount !== 3'd6) $display("FAIL fill_latency_early: pCount=%0d expected 6", pCount);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        n_total++;
        if ({pCount, fullFlag, wValid} !== {3'd7, 1'b1, 1'b0})
            $display("FAIL fill_full: pCount/full/wValid=%0d/%b/%b expected 7/1/0", pCount, fullFlag, wValid);
        else n_pass++;
        hi_at = 0; held_ok = 1'b1;
        for (int k = 1; k <= 12 && hi_at == 0; k++) begin
            @(posedge clk); @(negedge clk);
            if (wValid) hi_at = k;
            else if (wTime !== 8'd6) held_ok = 1'b0;
        end
        n_total++;
        if (hi_at != 6) $display("FAIL fill_wvalid_latency: rose after %0d cycles expected 6", hi_at);
        else n_pass++;
        n_total++;
        if ({held_ok, wTime} !== {1'b1, 8'd9})
            $display("FAIL fill_wtime: held_ok=%b wTime=%0d expected 1/9", held_ok, wTime);
        else n_pass++;
        #1 a = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_overflow;
        pulse_a(8);
        @(negedge clk);
        n_total++;
        if ({pCount, ovfFlag, wValid} !== {3'd7, 1'b1, 1'b1})
            $display("FAIL ovf_set: pCount/ovf/wValid=%0d/%b/%b expected 7/1/1", pCount, ovfFlag, wValid);
        else n_pass++;
        @(posedge clk); #1 clrErr = 1'b1;
        @(posedge clk); #1 clrErr = 1'b0;
        @(negedge clk);
        n_total++;
        if ({ovfFlag, fullFlag} !== 2'b01)
            $display("FAIL ovf_clear: ovf/full=%b/%b expected 0/1", ovfFlag, fullFlag);
        else n_pass++;
    endtask

    task automatic test_underflow;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        pulse_b(8);
        @(negedge clk);
        n_total++;
        if ({pCount, udfFlag, emptyFlag} !== {3'd0, 1'b1, 1'b1})
            $display("FAIL udf_set: pCount/udf/empty=%0d/%b/%b expected 0/1/1", pCount, udfFlag, emptyFlag);
        else n_pass++;
        @(posedge clk); #1 a = 1'b1; b = 1'b1;
        repeat (8) @(posedge clk);
        #1 a = 1'b0; b = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({pCount, udfFlag, ovfFlag, emptyFlag} !== {3'd1, 1'b1, 1'b0, 1'b0})
            $display("FAIL both_empty: pCount/udf/ovf/empty=%0d/%b/%b/%b expected 1/1/0/0",
                     pCount, udfFlag, ovfFlag, emptyFlag);
        else n_pass++;
    endtask

    task automatic test_div_restart;
        int hi_at;
        logic held_ok;
        @(posedge clk); #1 tCount = 2'd1;
        repeat (3) pulse_a(8);
        @(negedge clk);
        n_total++;
        if ({pCount, wValid, wTime} !== {3'd4, 1'b1, 8'd12})
            $display("FAIL div_t1: pCount/wValid/wTime=%0d/%b/%0d expected 4/1/12", pCount, wValid, wTime);
        else n_pass++;
        @(posedge clk); #1 tCount = 2'd3;
        repeat (3) @(posedge clk);
        #1 tCount = 2'd2;
        hi_at = 0; held_ok = 1'b1;
        for (int k = 1; k <= 20 && hi_at == 0; k++) begin
            @(posedge clk); @(negedge clk);
            if (wValid) hi_at = k;
            else if (wTime !== 8'd12) held_ok = 1'b0;
        end
        n_total++;
        if (hi_at != 7) $display("FAIL div_restart_latency: rose after %0d cycles expected 7", hi_at);
        else n_pass++;
        n_total++;
        if ({held_ok, wTime} !== {1'b1, 8'd6})
            $display("FAIL div_restart_wtime: held_ok=%b wTime=%0d expected 1/6", held_ok, wTime);
        else n_pass++;
    endtask

    task automatic test_tzero;
        @(posedge clk); #1 tCount = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({wValid, wTime} !== {1'b0, 8'd6})
            $display("FAIL tzero_early: wValid/wTime=%b/%0d expected 0/6", wValid, wTime);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        n_total++;
        if ({wValid, wTime} !== {1'b1, 8'd255})
            $display("FAIL tzero_sat: wValid/wTime=%b/%0d expected 1/255", wValid, wTime);
        else n_pass++;
    endtask

    task automatic test_async_reset;
        @(posedge clk); #1 tCount = 2'd1;
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({pCount, wValid, wTime, emptyFlag} !== {3'd0, 1'b1, 8'd0, 1'b1})
            $display("FAIL async_reset: pCount/wValid/wTime/empty=%0d/%b/%0d/%b expected 0/1/0/1",
                     pCount, wValid, wTime, emptyFlag);
        else n_pass++;
        @(posedge clk); #1 reset = 1'b1;
        repeat (10) @(posedge clk);
    endtask

`ifdef SBQM_DEBOUNCE_EN
    task automatic test_debounce;
        @(posedge clk); #1 a = 1'b1;
        repeat (2) @(posedge clk);
        #1 a = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (pCount !== 3'd0) $display("FAIL db_glitch: pCount=%0d expected 0", pCount);
        else n_pass++;
        @(posedge clk); #1 a = 1'b1;
        repeat (6) @(posedge clk);
        #1 a = 1'b0;
        @(negedge clk);
        n_total++;
        if (pCount !== 3'd0) $display("FAIL db_early: pCount=%0d expected 0", pCount);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (pCount !== 3'd1) $display("FAIL db_pulse: pCount=%0d expected 1", pCount);
        else n_pass++;
        repeat (10) @(posedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_underflow();
        test_div_restart();
        test_tzero();
        test_async_reset();
`ifdef SBQM_DEBOUNCE_EN
        test_debounce();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
